// File: rtl/matrix_tx_serializer.sv
// Serializes a matrix, one upstream row at a time, onto a 2-bit stream.
// The next row is fetched into a shadow buffer while the current row is sent, so the burst has no gaps.
module matrix_tx_serializer #(
    parameter int ELEMENT_SIZE = 8,
    parameter int ROW_ELEMENTS = 32,
    parameter int NUM_ROWS     = 32,
    localparam int ROW_W       = ROW_ELEMENTS * ELEMENT_SIZE,
    localparam int DIBITS      = ROW_W / 2,
    localparam int AW          = $clog2(NUM_ROWS)
) (
    input  logic             eth_refclk,
    input  logic             rst,
    input  logic             start,
    output logic             row_req,
    output logic [AW-1:0]    row_addr,
    input  logic             row_valid,
    input  logic [ROW_W-1:0] row_data,
    output logic             axiov,
    output logic [1:0]       axiod,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int DCW = (DIBITS > 1) ? $clog2(DIBITS) : 1;
    localparam logic [DCW-1:0] LAST_DIBIT = DCW'(DIBITS - 1);
    localparam logic [AW-1:0]  LAST_ROW   = AW'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        SEND     = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ROW_W-1:0] shift_reg, shift_nxt;
    logic [ROW_W-1:0] shadow, shadow_nxt;
    logic             shadow_full, shadow_full_nxt;
    logic             req_pending, req_pending_nxt;
    logic [DCW-1:0]   dibit_cnt, dibit_cnt_nxt;
    logic [AW-1:0]    row_cnt, row_cnt_nxt;
    logic             row_req_nxt, axiov_nxt, busy_nxt, done_nxt, underrun_nxt;
    logic [AW-1:0]    row_addr_nxt;
    logic [1:0]       axiod_nxt;
    logic             load_en;
    logic [ROW_W-1:0] load_data;
    logic [AW-1:0]    load_row;

    // State and datapath registers; every output is registered.
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            req_pending <= 1'b0;
            dibit_cnt   <= '0;
            row_cnt     <= '0;
            row_req     <= 1'b0;
            row_addr    <= '0;
            axiov       <= 1'b0;
            axiod       <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            shadow      <= shadow_nxt;
            shadow_full <= shadow_full_nxt;
            req_pending <= req_pending_nxt;
            dibit_cnt   <= dibit_cnt_nxt;
            row_cnt     <= row_cnt_nxt;
            row_req     <= row_req_nxt;
            row_addr    <= row_addr_nxt;
            axiov       <= axiov_nxt;
            axiod       <= axiod_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            underrun    <= underrun_nxt;
        end
    end

    // Next-state, row fetch/shadow handling and stream output selection.
    always_comb begin
        state_nxt       = state;
        shift_nxt       = shift_reg;
        shadow_nxt      = shadow;
        shadow_full_nxt = shadow_full;
        req_pending_nxt = req_pending;
        dibit_cnt_nxt   = dibit_cnt;
        row_cnt_nxt     = row_cnt;
        row_req_nxt     = 1'b0;
        row_addr_nxt    = row_addr;
        axiov_nxt       = 1'b0;
        axiod_nxt       = 2'b00;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        underrun_nxt    = 1'b0;
        load_en         = 1'b0;
        load_data       = row_data;
        load_row        = row_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt       = PREFETCH;
                    row_req_nxt     = 1'b1;
                    row_addr_nxt    = '0;
                    busy_nxt        = 1'b1;
                    req_pending_nxt = 1'b1;
                    shadow_full_nxt = 1'b0;
                end else begin
                    busy_nxt = 1'b0;
                end
            end
            PREFETCH: begin
                if (row_valid) begin
                    load_en  = 1'b1;
                    load_row = '0;
                end else begin
                    load_en = 1'b0;
                end
            end
            SEND: begin
                if (row_valid && req_pending && !shadow_full) begin
                    shadow_nxt      = row_data;
                    shadow_full_nxt = 1'b1;
                    req_pending_nxt = 1'b0;
                end else begin
                    shadow_nxt = shadow;
                end
                if (dibit_cnt != LAST_DIBIT) begin
                    axiov_nxt     = 1'b1;
                    axiod_nxt     = shift_reg[ROW_W-1 -: 2];
                    shift_nxt     = shift_reg << 2;
                    dibit_cnt_nxt = dibit_cnt + DCW'(1);
                end else if (row_cnt == LAST_ROW) begin
                    state_nxt       = IDLE;
                    busy_nxt        = 1'b0;
                    done_nxt        = 1'b1;
                    req_pending_nxt = 1'b0;
                    shadow_full_nxt = 1'b0;
                end else if (shadow_full) begin
                    load_en   = 1'b1;
                    load_data = shadow;
                    load_row  = row_cnt + AW'(1);
                end else if (row_valid && req_pending) begin
                    load_en  = 1'b1;
                    load_row = row_cnt + AW'(1);
                end else begin
                    // Next row is late: abort and forget the outstanding request.
                    state_nxt       = IDLE;
                    busy_nxt        = 1'b0;
                    underrun_nxt    = 1'b1;
                    req_pending_nxt = 1'b0;
                    shadow_full_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Loading a row puts its first dibit on the bus and prefetches the following row.
        if (load_en) begin
            state_nxt       = SEND;
            axiov_nxt       = 1'b1;
            axiod_nxt       = load_data[ROW_W-1 -: 2];
            shift_nxt       = load_data << 2;
            dibit_cnt_nxt   = '0;
            row_cnt_nxt     = load_row;
            shadow_full_nxt = 1'b0;
            if (load_row != LAST_ROW) begin
                row_req_nxt     = 1'b1;
                row_addr_nxt    = load_row + AW'(1);
                req_pending_nxt = 1'b1;
            end else begin
                req_pending_nxt = 1'b0;
            end
        end else begin
            load_row = load_row;
        end
    end

endmodule

// File: tb/tb_matrix_tx_serializer.sv
// Randomized self-checking bench: a row-buffer responder with programmable latency feeds the DUT,
// and the received stream is compared with dibits computed directly from the matrix contents.
module tb_matrix_tx_serializer;

    localparam int ES = 8, RE = 32, NR = 32, RW = ES * RE, DB = RW / 2, TOTAL = NR * DB;

    logic          clk = 1'b0;
    logic          rst, start, row_valid;
    logic [RW-1:0] row_data;
    logic          row_req, axiov, busy, done, underrun;
    logic [4:0]    row_addr;
    logic [1:0]    axiod;

    logic          s_start, s_row_valid;
    logic [15:0]   s_row_data;
    logic          s_row_req, s_axiov, s_busy, s_done, s_underrun;
    logic [0:0]    s_row_addr;
    logic [1:0]    s_axiod;

    always #5 clk = ~clk;

    matrix_tx_serializer dut (
        .eth_refclk(clk), .rst(rst), .start(start), .row_req(row_req), .row_addr(row_addr),
        .row_valid(row_valid), .row_data(row_data), .axiov(axiov), .axiod(axiod),
        .busy(busy), .done(done), .underrun(underrun));

    matrix_tx_serializer #(.ELEMENT_SIZE(4), .ROW_ELEMENTS(4), .NUM_ROWS(2)) dut_small (
        .eth_refclk(clk), .rst(rst), .start(s_start), .row_req(s_row_req), .row_addr(s_row_addr),
        .row_valid(s_row_valid), .row_data(s_row_data), .axiov(s_axiov), .axiod(s_axiod),
        .busy(s_busy), .done(s_done), .underrun(s_underrun));

    int checks = 0, failures = 0, cyc = 0;
    int mat[NR][RE];
    int n_v, gap, stream_err, zero_err, busy_err, over, done_cnt, und_cnt;
    int done_cyc, und_cyc, last_v_cyc, busy_at_end, start_ok, rst_ok, timed_out;
    int f4[4];
    int addr_log[$];

    function automatic logic [RW-1:0] row_vec(input int a);
        logic [RW-1:0] v;
        v = '0;
        for (int c = 0; c < RE; c++) v[RW-1-ES*c -: ES] = 8'(mat[a][c]);
        return v;
    endfunction

    // Dibit i of the burst: row-major elements, most significant pair of each element first.
    function automatic int exp_dibit(input int i);
        int r, j, c, k;
        r = i / DB; j = i % DB; c = j / (ES/2); k = j % (ES/2);
        return (mat[r][c] >> (ES - 2 - 2*k)) & 3;
    endfunction

    task automatic fill_random();
        for (int r = 0; r < NR; r++) for (int c = 0; c < RE; c++) mat[r][c] = int'($urandom_range(0, 255));
    endtask

    // inject: 0 none, 1 unsolicited row_valid + start mid-burst, 2 reset at row 5 dibit 60
    task automatic run_burst(input int lat, input int inject);
        int due, addr;
        bit fin, rst_pending;
        n_v = 0; gap = 0; stream_err = 0; zero_err = 0; busy_err = 0; over = 0;
        done_cnt = 0; und_cnt = 0; done_cyc = -1; und_cyc = -1; last_v_cyc = -1;
        busy_at_end = -1; start_ok = 0; rst_ok = 0; timed_out = 0;
        for (int i = 0; i < 4; i++) f4[i] = -1;
        addr_log.delete();
        due = -1; addr = 0; fin = 0; rst_pending = 0;
        for (int it = 0; it < 6000 && !fin; it++) begin
            @(posedge clk); #1; cyc++;
            if (rst_pending) begin
                rst_ok = (axiov === 1'b0 && axiod === 2'b00 && row_req === 1'b0 && row_addr === 5'd0 &&
                          busy === 1'b0 && done === 1'b0 && underrun === 1'b0);
                rst = 1'b0; start = 1'b0; row_valid = 1'b0; fin = 1;
            end else begin
                if (axiov) begin
                    if (n_v > 0 && last_v_cyc != cyc - 1) gap++;
                    if (n_v < TOTAL) begin
                        if (axiod !== 2'(exp_dibit(n_v))) stream_err++;
                    end else over++;
                    if (n_v < 4) f4[n_v] = int'(axiod);
                    if (!busy) busy_err++;
                    n_v++; last_v_cyc = cyc;
                end else if (axiod !== 2'b00) zero_err++;
                if (it == 1) start_ok = (row_req === 1'b1 && row_addr === 5'd0 && busy === 1'b1);
                if (row_req) addr_log.push_back(int'(row_addr));
                if (done) begin done_cnt++; done_cyc = cyc; busy_at_end = int'(busy); fin = 1; end
                if (underrun) begin und_cnt++; und_cyc = cyc; busy_at_end = int'(busy); fin = 1; end
                start = (it == 0) || (inject == 1 && n_v == 1000);
                row_valid = 1'b0;
                row_data = {8{$urandom}};
                if (row_req) begin
                    due = cyc + ((lat < 0) ? int'($urandom_range(0, DB-1)) : lat);
                    addr = int'(row_addr);
                end
                if (due == cyc) begin
                    row_valid = 1'b1; row_data = row_vec(addr); due = -1;
                end else if (inject == 1 && n_v >= 31*DB + 10 && n_v < 31*DB + 13) begin
                    row_valid = 1'b1;
                end
                if (inject == 2 && axiov && n_v == 5*DB + 61) begin rst = 1'b1; rst_pending = 1; end
            end
        end
        start = 1'b0; row_valid = 1'b0;
        if (!fin) timed_out = 1;
    endtask

    task automatic check_full(input string tag);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL %s_timeout: got %0d want 0", tag, timed_out); end
        checks++; if (n_v !== TOTAL) begin failures++; $display("FAIL %s_len: got %0d want %0d", tag, n_v, TOTAL); end
        checks++; if (gap !== 0) begin failures++; $display("FAIL %s_gap: got %0d want 0", tag, gap); end
        checks++; if (stream_err !== 0 || zero_err !== 0 || busy_err !== 0) begin failures++;
            $display("FAIL %s_stream: errs %0d/%0d/%0d want 0/0/0", tag, stream_err, zero_err, busy_err); end
        checks++; if (done_cnt !== 1 || done_cyc !== last_v_cyc + 1 || und_cnt !== 0 || busy_at_end !== 0) begin failures++;
            $display("FAIL %s_done: done_cnt=%0d at %0d last_v=%0d und=%0d busy=%0d", tag, done_cnt, done_cyc, last_v_cyc, und_cnt, busy_at_end); end
    endtask

    task automatic check_addrs(input string tag);
        int bad;
        bad = (addr_log.size() != NR) ? 1 : 0;
        for (int i = 0; i < addr_log.size() && i < NR; i++) if (addr_log[i] != i) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL %s_addr_seq: got %0d requests, %0d bad, want 0..31", tag, addr_log.size(), bad); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; row_valid = 1'b0; row_data = '0;
        s_start = 1'b0; s_row_valid = 1'b0; s_row_data = '0;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        checks++;
        if ({axiov, axiod, row_req, row_addr, busy, done, underrun} !== 12'd0) begin failures++;
            $display("FAIL reset_main: got %b want 0", {axiov, axiod, row_req, row_addr, busy, done, underrun}); end
        checks++;
        if ({s_axiov, s_axiod, s_row_req, s_row_addr, s_busy, s_done, s_underrun} !== 8'd0) begin failures++;
            $display("FAIL reset_small: got %b want 0", {s_axiov, s_axiod, s_row_req, s_row_addr, s_busy, s_done, s_underrun}); end
        rst = 1'b0;
    endtask

    task automatic test_full_matrix();
        for (int r = 0; r < NR; r++) for (int c = 0; c < RE; c++) mat[r][c] = (r*32 + c) % 256;
        mat[0][0] = 8'hA5;
        run_burst(2, 0);
        checks++; if (start_ok !== 1) begin failures++; $display("FAIL start_latency: got %0d want 1", start_ok); end
        checks++; if (f4[0] !== 2 || f4[1] !== 2 || f4[2] !== 1 || f4[3] !== 1) begin failures++;
            $display("FAIL first_dibits: got %0d,%0d,%0d,%0d want 2,2,1,1", f4[0], f4[1], f4[2], f4[3]); end
        check_full("full");
        check_addrs("full");
        @(posedge clk); #1; cyc++;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_latency_127();
        fill_random(); run_burst(127, 0); check_full("lat127");
    endtask

    task automatic test_latency_128();
        fill_random(); run_burst(128, 0);
        checks++; if (n_v !== DB || stream_err !== 0) begin failures++; $display("FAIL lat128_len: got %0d errs %0d want %0d 0", n_v, stream_err, DB); end
        checks++; if (und_cnt !== 1 || und_cyc !== last_v_cyc + 1 || busy_at_end !== 0 || done_cnt !== 0) begin failures++;
            $display("FAIL lat128_underrun: und=%0d at %0d last_v=%0d busy=%0d done=%0d", und_cnt, und_cyc, last_v_cyc, busy_at_end, done_cnt); end
        @(posedge clk); #1; cyc++;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_pulse: got %b want 0", underrun); end
    endtask

    task automatic test_random_latency();
        fill_random(); run_burst(-1, 0); check_full("randlat"); check_addrs("randlat");
    endtask

    task automatic test_unsolicited_and_start();
        fill_random(); run_burst(3, 1); check_full("unsol"); check_addrs("unsol");
    endtask

    task automatic test_reset_mid();
        fill_random(); run_burst(2, 2);
        checks++; if (rst_ok !== 1) begin failures++; $display("FAIL rst_mid_outputs: got %0d want 1", rst_ok); end
        checks++; if (n_v !== 5*DB + 61 || done_cnt !== 0 || und_cnt !== 0) begin failures++;
            $display("FAIL rst_mid_pulses: n_v=%0d done=%0d und=%0d want %0d 0 0", n_v, done_cnt, und_cnt, 5*DB + 61); end
        fill_random(); run_burst(2, 0);
        checks++; if (start_ok !== 1) begin failures++; $display("FAIL rst_restart_addr0: got %0d want 1", start_ok); end
        check_full("after_rst"); check_addrs("after_rst");
    endtask

    task automatic test_back_to_back();
        fill_random(); run_burst(5, 0); check_full("b2b_first");
        fill_random(); run_burst(0, 0);
        checks++; if (start_ok !== 1) begin failures++; $display("FAIL b2b_start_latency: got %0d want 1", start_ok); end
        check_full("b2b_second");
    endtask

    task automatic test_small();
        int sm[2][4];
        int n, err, gp, dcnt, dcyc, last, due, addr;
        logic [15:0] v;
        bit fin;
        for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) sm[r][c] = int'($urandom_range(0, 15));
        n = 0; err = 0; gp = 0; dcnt = 0; dcyc = -1; last = -1; due = -1; addr = 0; fin = 0;
        for (int it = 0; it < 200 && !fin; it++) begin
            @(posedge clk); #1; cyc++;
            if (s_axiov) begin
                if (n > 0 && last != cyc - 1) gp++;
                if (n < 16) begin
                    if (int'(s_axiod) != ((sm[n/8][(n%8)/2] >> (2 - 2*(n%2))) & 3)) err++;
                end else err++;
                n++; last = cyc;
            end
            if (s_done || s_underrun) fin = 1;
            if (s_done) begin dcnt++; dcyc = cyc; end
            s_start = (it == 0);
            s_row_valid = 1'b0; s_row_data = 16'($urandom);
            if (s_row_req) begin due = cyc + int'($urandom_range(0, 7)); addr = int'(s_row_addr); end
            if (due == cyc) begin
                for (int c = 0; c < 4; c++) v[15-4*c -: 4] = 4'(sm[addr][c]);
                s_row_valid = 1'b1; s_row_data = v; due = -1;
            end
        end
        s_start = 1'b0; s_row_valid = 1'b0;
        checks++; if (n !== 16 || gp !== 0 || err !== 0) begin failures++; $display("FAIL small_stream: len=%0d gap=%0d errs=%0d want 16 0 0", n, gp, err); end
        checks++; if (dcnt !== 1 || dcyc !== last + 1) begin failures++; $display("FAIL small_done: cnt=%0d at %0d last=%0d", dcnt, dcyc, last); end
    endtask

    initial begin
        test_reset();
        test_full_matrix();
        test_latency_127();
        test_latency_128();
        test_random_latency();
        test_unsolicited_and_start();
        test_reset_mid();
        test_back_to_back();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
